// File: rtl/ctrl_pkg.sv
// Shared definitions for the fetch/decode/control sequencer and the datapath it drives:
// opcodes, ALU codes, writeback selects, FSM states and instruction field positions.
package ctrl_pkg;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_AND = 4'h3;
    localparam logic [3:0] OP_OR  = 4'h4;
    localparam logic [3:0] OP_XOR = 4'h5;
    localparam logic [3:0] OP_NOT = 4'h6;
    localparam logic [3:0] OP_MOV = 4'h7;
    localparam logic [3:0] OP_LDI = 4'h8;
    localparam logic [3:0] OP_JMP = 4'h9;
    localparam logic [3:0] OP_BZ  = 4'hA;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [2:0] ALU_ADD    = 3'd0;
    localparam logic [2:0] ALU_SUB    = 3'd1;
    localparam logic [2:0] ALU_AND    = 3'd2;
    localparam logic [2:0] ALU_OR     = 3'd3;
    localparam logic [2:0] ALU_XOR    = 3'd4;
    localparam logic [2:0] ALU_NOT    = 3'd5;
    localparam logic [2:0] ALU_PASS_B = 3'd6;

    localparam logic WB_ALU = 1'b0;
    localparam logic WB_IMM = 1'b1;

    localparam int OPC_HI = 7;
    localparam int OPC_LO = 4;
    localparam int RD_HI  = 3;
    localparam int RD_LO  = 2;
    localparam int RS_HI  = 1;
    localparam int RS_LO  = 0;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_FETCH_IMM,
        ST_EXEC,
        ST_HALT
    } state_t;

endpackage

// File: rtl/ctrl_decode.sv
// Purely combinational opcode decoder: classifies an opcode and supplies the ALU code
// and writeback select used by the sequencer.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [3:0] opcode,
    output logic [2:0] alu_op,
    output logic       wb_sel,
    output logic       writes_rd,
    output logic       needs_imm,
    output logic       is_jmp,
    output logic       is_bz,
    output logic       is_hlt,
    output logic       is_illegal
);

    always_comb begin
        alu_op     = ALU_ADD;
        wb_sel     = WB_ALU;
        writes_rd  = 1'b0;
        needs_imm  = 1'b0;
        is_jmp     = 1'b0;
        is_bz      = 1'b0;
        is_hlt     = 1'b0;
        is_illegal = 1'b0;
        case (opcode)
            OP_NOP: ;
            OP_ADD: begin alu_op = ALU_ADD;    writes_rd = 1'b1; end
            OP_SUB: begin alu_op = ALU_SUB;    writes_rd = 1'b1; end
            OP_AND: begin alu_op = ALU_AND;    writes_rd = 1'b1; end
            OP_OR:  begin alu_op = ALU_OR;     writes_rd = 1'b1; end
            OP_XOR: begin alu_op = ALU_XOR;    writes_rd = 1'b1; end
            OP_NOT: begin alu_op = ALU_NOT;    writes_rd = 1'b1; end
            OP_MOV: begin alu_op = ALU_PASS_B; writes_rd = 1'b1; end
            OP_LDI: begin wb_sel = WB_IMM; writes_rd = 1'b1; needs_imm = 1'b1; end
            OP_JMP: begin needs_imm = 1'b1; is_jmp = 1'b1; end
            // BZ compares rd against rs, so the ALU subtracts to produce zero_flag
            OP_BZ:  begin alu_op = ALU_SUB; needs_imm = 1'b1; is_bz = 1'b1; end
            OP_HLT: is_hlt = 1'b1;
            default: is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/ctrl_unit.sv
// Multi-cycle fetch/decode/control sequencer: fetches instructions over a req/ack port,
// drives register-file selects and ALU controls, and owns the PC.
module ctrl_unit
    import ctrl_pkg::*;
#(
    parameter int              PC_W   = 8,
    parameter logic [PC_W-1:0] RST_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [7:0]      imem_data,
    input  logic            zero_flag,
    output logic [1:0]      src1,
    output logic [1:0]      src2,
    output logic [1:0]      dst,
    output logic            we,
    output logic [2:0]      alu_op,
    output logic            wb_sel,
    output logic [7:0]      imm,
    output logic            halted,
    output logic            illegal
);

    state_t          state;
    state_t          state_nx;
    logic [PC_W-1:0] pc;
    logic [7:0]      ir;
    logic            fetching;

    logic [2:0] dec_alu_op;
    logic       dec_wb_sel;
    logic       writes_rd;
    logic       needs_imm;
    logic       is_jmp;
    logic       is_bz;
    logic       is_hlt;
    logic       is_illegal;

    ctrl_decode u_decode (
        .opcode     (ir[OPC_HI:OPC_LO]),
        .alu_op     (dec_alu_op),
        .wb_sel     (dec_wb_sel),
        .writes_rd  (writes_rd),
        .needs_imm  (needs_imm),
        .is_jmp     (is_jmp),
        .is_bz      (is_bz),
        .is_hlt     (is_hlt),
        .is_illegal (is_illegal)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_FETCH;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_FETCH:     if (imem_ack) state_nx = ST_DECODE;
            ST_DECODE: begin
                if (needs_imm)   state_nx = ST_FETCH_IMM;
                else if (is_hlt) state_nx = ST_HALT;
                else             state_nx = ST_EXEC;
            end
            ST_FETCH_IMM: if (imem_ack) state_nx = ST_EXEC;
            ST_EXEC:      state_nx = ST_FETCH;
            ST_HALT:      state_nx = ST_HALT;
            default:      state_nx = ST_FETCH;
        endcase
    end

    // Request is gated by reset so the port is quiet while reset is held, even though
    // the state register already sits in FETCH.
    assign fetching  = (state == ST_FETCH) || (state == ST_FETCH_IMM);
    assign imem_req  = rst && fetching;
    assign imem_addr = pc;
    assign we        = (state == ST_EXEC) && writes_rd;
    assign illegal   = (state == ST_DECODE) && is_illegal;
    assign halted    = (state == ST_HALT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc     <= RST_PC;
            ir     <= '0;
            imm    <= '0;
            src1   <= '0;
            src2   <= '0;
            dst    <= '0;
            alu_op <= ALU_ADD;
            wb_sel <= WB_ALU;
        end else begin
            case (state)
                ST_FETCH: begin
                    if (imem_ack) begin
                        ir <= imem_data;
                        pc <= pc + PC_W'(1);
                    end
                end
                ST_DECODE: begin
                    src1   <= ir[RD_HI:RD_LO];
                    src2   <= ir[RS_HI:RS_LO];
                    dst    <= ir[RD_HI:RD_LO];
                    alu_op <= dec_alu_op;
                    wb_sel <= dec_wb_sel;
                end
                ST_FETCH_IMM: begin
                    if (imem_ack) begin
                        imm <= imem_data;
                        pc  <= pc + PC_W'(1);
                    end
                end
                ST_EXEC: begin
                    if (is_jmp || (is_bz && zero_flag)) pc <= PC_W'(imm);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ctrl_unit.sv
// Directed testbench for ctrl_unit: a tiny instruction memory with programmable ack
// latency, one task per scenario, hand-computed expectations.
module tb_ctrl_unit;

    logic       clk;
    logic       rst;
    logic       imem_req;
    logic [7:0] imem_addr;
    logic       imem_ack;
    logic [7:0] imem_data;
    logic       zero_flag;
    logic [1:0] src1;
    logic [1:0] src2;
    logic [1:0] dst;
    logic       we;
    logic [2:0] alu_op;
    logic       wb_sel;
    logic [7:0] imm;
    logic       halted;
    logic       illegal;

    logic [7:0] mem [0:255];
    int         ack_delay;
    int         wait_cnt;
    logic       spurious;

    int vectors;
    int miscompares;

    ctrl_unit #(.PC_W(8), .RST_PC(8'h00)) dut (
        .clk       (clk),
        .rst       (rst),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_ack  (imem_ack),
        .imem_data (imem_data),
        .zero_flag (zero_flag),
        .src1      (src1),
        .src2      (src2),
        .dst       (dst),
        .we        (we),
        .alu_op    (alu_op),
        .wb_sel    (wb_sel),
        .imm       (imm),
        .halted    (halted),
        .illegal   (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory responder: ack arrives once the request has been pending ack_delay cycles.
    assign imem_data = mem[imem_addr];
    assign imem_ack  = spurious | (imem_req && (wait_cnt >= ack_delay));

    always @(negedge clk) begin
        if (imem_req && !imem_ack) wait_cnt = wait_cnt + 1;
        else                       wait_cnt = 0;
    end

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic restart();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
    endtask

    task automatic load_prog(input logic [7:0] w0, input logic [7:0] w1);
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[0] = w0;
        mem[1] = w1;
    endtask

    task automatic test_reset();
        spurious = 1'b1;
        repeat (3) cyc();
        vectors++;
        if ({imem_req, we, halted, illegal} !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL reset_ctrl: got req/we/halt/ill=%b expected 0000", {imem_req, we, halted, illegal});
        end
        vectors++;
        if (imem_addr !== 8'h00) begin
            miscompares++;
            $display("[TB] FAIL reset_addr: got %h expected 00", imem_addr);
        end
        vectors++;
        if ({src1, src2, dst, alu_op, wb_sel, imm} !== 18'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_dp: got %h expected 0", {src1, src2, dst, alu_op, wb_sel, imm});
        end
        spurious = 1'b0;
    endtask

    task automatic test_ldi();
        ack_delay = 0;
        load_prog(8'h81, 8'h5A);
        restart();
        vectors++;
        if ({imem_req, imem_addr} !== {1'b1, 8'h00}) begin
            miscompares++;
            $display("[TB] FAIL ldi_fetch0: got req=%b addr=%h expected req=1 addr=00", imem_req, imem_addr);
        end
        cyc();
        vectors++;
        if ({imem_req, we} !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL ldi_decode: got req/we=%b expected 00", {imem_req, we});
        end
        cyc();
        vectors++;
        if ({imem_req, imem_addr} !== {1'b1, 8'h01}) begin
            miscompares++;
            $display("[TB] FAIL ldi_fetch1: got req=%b addr=%h expected req=1 addr=01", imem_req, imem_addr);
        end
        cyc();
        vectors++;
        if ({we, dst, wb_sel, imm} !== {1'b1, 2'd0, 1'b1, 8'h5A}) begin
            miscompares++;
            $display("[TB] FAIL ldi_exec: got we=%b dst=%0d wb=%b imm=%h expected we=1 dst=0 wb=1 imm=5a", we, dst, wb_sel, imm);
        end
        cyc();
        vectors++;
        if ({imem_req, imem_addr, we} !== {1'b1, 8'h02, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL ldi_next: got req=%b addr=%h we=%b expected req=1 addr=02 we=0", imem_req, imem_addr, we);
        end
    endtask

    task automatic test_add_wait();
        ack_delay = 3;
        load_prog(8'h16, 8'h00);
        restart();
        for (int c = 0; c < 4; c++) begin
            if (c > 0) cyc();
            vectors++;
            if ({imem_req, imem_addr} !== {1'b1, 8'h00}) begin
                miscompares++;
                $display("[TB] FAIL add_hold%0d: got req=%b addr=%h expected req=1 addr=00", c, imem_req, imem_addr);
            end
        end
        cyc();
        vectors++;
        if ({imem_req, we} !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL add_decode: got req/we=%b expected 00", {imem_req, we});
        end
        cyc();
        vectors++;
        if ({src1, src2, dst, alu_op, wb_sel, we} !== {2'd1, 2'd2, 2'd1, 3'd0, 1'b0, 1'b1}) begin
            miscompares++;
            $display("[TB] FAIL add_exec: got s1=%0d s2=%0d d=%0d op=%0d wb=%b we=%b expected 1 2 1 0 0 1", src1, src2, dst, alu_op, wb_sel, we);
        end
        cyc();
        vectors++;
        if ({we, imem_req, imem_addr} !== {1'b0, 1'b1, 8'h01}) begin
            miscompares++;
            $display("[TB] FAIL add_after: got we=%b req=%b addr=%h expected we=0 req=1 addr=01", we, imem_req, imem_addr);
        end
        ack_delay = 0;
    endtask

    task automatic test_jmp_wrap();
        int         we_hits;
        logic [8:0] s4, s7, s10;
        we_hits = 0;
        s4 = '0; s7 = '0; s10 = '0;
        ack_delay = 0;
        load_prog(8'h90, 8'hFE);
        restart();
        for (int c = 0; c <= 10; c++) begin
            if (c > 0) cyc();
            if (we) we_hits++;
            if (c == 4)  s4  = {imem_req, imem_addr};
            if (c == 7)  s7  = {imem_req, imem_addr};
            if (c == 10) s10 = {imem_req, imem_addr};
        end
        vectors++;
        if (s4 !== {1'b1, 8'hFE}) begin
            miscompares++;
            $display("[TB] FAIL jmp_target: got req/addr=%h expected 1fe", s4);
        end
        vectors++;
        if (s7 !== {1'b1, 8'hFF}) begin
            miscompares++;
            $display("[TB] FAIL jmp_ff: got req/addr=%h expected 1ff", s7);
        end
        vectors++;
        if (s10 !== {1'b1, 8'h00}) begin
            miscompares++;
            $display("[TB] FAIL jmp_wrap: got req/addr=%h expected 100", s10);
        end
        vectors++;
        if (we_hits !== 0) begin
            miscompares++;
            $display("[TB] FAIL jmp_nowrite: got %0d we cycles expected 0", we_hits);
        end
    endtask

    task automatic test_bz();
        ack_delay = 0;
        load_prog(8'hA5, 8'h40);
        zero_flag = 1'b1;
        restart();
        repeat (3) cyc();
        vectors++;
        if ({src1, src2, we} !== {2'd1, 2'd1, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL bz_exec: got s1=%0d s2=%0d we=%b expected 1 1 0", src1, src2, we);
        end
        cyc();
        vectors++;
        if ({imem_req, imem_addr} !== {1'b1, 8'h40}) begin
            miscompares++;
            $display("[TB] FAIL bz_taken: got req=%b addr=%h expected req=1 addr=40", imem_req, imem_addr);
        end
        zero_flag = 1'b0;
        restart();
        repeat (4) cyc();
        vectors++;
        if ({imem_req, imem_addr} !== {1'b1, 8'h02}) begin
            miscompares++;
            $display("[TB] FAIL bz_not_taken: got req=%b addr=%h expected req=1 addr=02", imem_req, imem_addr);
        end
    endtask

    task automatic test_illegal_halt();
        int ill_hits;
        int req_hits;
        int we_hits;
        int run_lows;
        ill_hits = 0; req_hits = 0; we_hits = 0; run_lows = 0;
        ack_delay = 0;
        load_prog(8'hC3, 8'hF0);
        restart();
        if (illegal) ill_hits++;
        cyc();
        vectors++;
        if (illegal !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL ill_pulse: got %b expected 1", illegal);
        end
        if (illegal) ill_hits++;
        cyc();
        if (illegal) ill_hits++;
        vectors++;
        if (we !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL ill_nowrite: got we=%b expected 0", we);
        end
        vectors++;
        if (ill_hits !== 1) begin
            miscompares++;
            $display("[TB] FAIL ill_width: got %0d cycles expected 1", ill_hits);
        end
        cyc();
        vectors++;
        if ({imem_req, imem_addr} !== {1'b1, 8'h01}) begin
            miscompares++;
            $display("[TB] FAIL ill_next: got req=%b addr=%h expected req=1 addr=01", imem_req, imem_addr);
        end
        repeat (2) cyc();
        vectors++;
        if (halted !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL hlt_enter: got %b expected 1", halted);
        end
        spurious = 1'b1;
        for (int c = 0; c < 20; c++) begin
            cyc();
            if (imem_req) req_hits++;
            if (we) we_hits++;
            if (!halted) run_lows++;
        end
        spurious = 1'b0;
        vectors++;
        if ({req_hits, we_hits, run_lows} !== {32'd0, 32'd0, 32'd0}) begin
            miscompares++;
            $display("[TB] FAIL hlt_stay: got req=%0d we=%0d unhalted=%0d expected 0 0 0", req_hits, we_hits, run_lows);
        end
    endtask

    task automatic test_reset_mid();
        int bad;
        bad = 0;
        ack_delay = 2;
        load_prog(8'h81, 8'h33);
        restart();
        repeat (5) cyc();
        vectors++;
        if ({imem_req, imem_addr} !== {1'b1, 8'h01}) begin
            miscompares++;
            $display("[TB] FAIL mid_in_imm: got req=%b addr=%h expected req=1 addr=01", imem_req, imem_addr);
        end
        #1 rst = 1'b0;
        #1;
        vectors++;
        if ({imem_req, imem_addr, we, halted, dst, wb_sel, imm} !== 22'h0) begin
            miscompares++;
            $display("[TB] FAIL mid_async: got %h expected 0", {imem_req, imem_addr, we, halted, dst, wb_sel, imm});
        end
        spurious = 1'b1;
        for (int c = 0; c < 2; c++) begin
            cyc();
            if (we || imem_req) bad++;
        end
        spurious = 1'b0;
        vectors++;
        if (bad !== 0) begin
            miscompares++;
            $display("[TB] FAIL mid_stale_ack: got %0d active cycles expected 0", bad);
        end
        ack_delay = 0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        vectors++;
        if ({imem_req, imem_addr} !== {1'b1, 8'h00}) begin
            miscompares++;
            $display("[TB] FAIL mid_restart: got req=%b addr=%h expected req=1 addr=00", imem_req, imem_addr);
        end
        repeat (3) cyc();
        vectors++;
        if ({we, dst, imm} !== {1'b1, 2'd0, 8'h33}) begin
            miscompares++;
            $display("[TB] FAIL mid_refetch: got we=%b dst=%0d imm=%h expected we=1 dst=0 imm=33", we, dst, imm);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b0;
        zero_flag   = 1'b0;
        spurious    = 1'b0;
        ack_delay   = 0;
        wait_cnt    = 0;
        load_prog(8'h00, 8'h00);
        $display("[TB] starting ctrl_unit directed tests");
        test_reset();
        test_ldi();
        test_add_wait();
        test_jmp_wrap();
        test_bz();
        test_illegal_halt();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
